// File: rtl/mem_port_arbiter.sv
// Shares the single-ported unified memory between instruction fetch and load/store.
// Grants one requester at a time, aligns byte lanes, extends loads, flags misalignment and timeouts.
module mem_port_arbiter #(
    parameter int STREAK_MAX = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [1:0]  d_size,
    input  logic        d_unsigned,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_done,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);
    // Handshake: if_req/d_req are levels held until the matching one-cycle done pulse,
    // which qualifies rdata/err. mem_req stays high with mem_* stable until a single-cycle
    // mem_ack or the timeout; an ack seen in any other state is dropped.
    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D, RESP} state_t;

    localparam logic [3:0] STREAK_LIM = 4'(STREAK_MAX);
    localparam logic [7:0] WAIT_LIM   = 8'(TIMEOUT - 1);

    state_t      state;
    logic [3:0]  streak;
    logic [7:0]  wait_cnt;
    logic        q_we;
    logic        q_unsigned;
    logic [1:0]  q_size;
    logic [1:0]  q_lane;

    logic        grant_d;
    logic        grant_if;
    logic        d_bad;
    logic [3:0]  d_be;
    logic [31:0] d_wdata_rep;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_data;
    logic        if_addr_unused;

    assign if_addr_unused = ^if_addr[1:0];

    always_comb begin
        grant_d  = d_req && !(if_req && streak == STREAK_LIM);
        grant_if = if_req && !grant_d;
        d_bad    = (d_size == 2'b11) ||
                   (d_size == 2'b01 && d_addr[0]) ||
                   (d_size == 2'b10 && d_addr[1:0] != 2'b00);
        case (d_size)
            2'b00: begin
                d_be        = 4'b0001 << d_addr[1:0];
                d_wdata_rep = {4{d_wdata[7:0]}};
            end
            2'b01: begin
                d_be        = d_addr[1] ? 4'b1100 : 4'b0011;
                d_wdata_rep = {2{d_wdata[15:0]}};
            end
            default: begin
                d_be        = 4'b1111;
                d_wdata_rep = d_wdata;
            end
        endcase
    end

    // Lane select uses the byte offset captured at grant time.
    always_comb begin
        ld_byte = mem_rdata[{q_lane, 3'b000} +: 8];
        ld_half = mem_rdata[{q_lane[1], 4'b0000} +: 16];
        case (q_size)
            2'b00:   load_data = {{24{ld_byte[7] & ~q_unsigned}}, ld_byte};
            2'b01:   load_data = {{16{ld_half[15] & ~q_unsigned}}, ld_half};
            default: load_data = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            streak     <= 4'd0;
            wait_cnt   <= 8'd0;
            q_we       <= 1'b0;
            q_unsigned <= 1'b0;
            q_size     <= 2'b00;
            q_lane     <= 2'b00;
            if_done    <= 1'b0;
            if_rdata   <= 32'd0;
            if_err     <= 1'b0;
            d_done     <= 1'b0;
            d_rdata    <= 32'd0;
            d_err      <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 32'd0;
            mem_be     <= 4'd0;
            mem_wdata  <= 32'd0;
        end else begin
            if_done <= 1'b0;
            if_err  <= 1'b0;
            d_done  <= 1'b0;
            d_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        streak     <= if_req ? streak + 4'd1 : 4'd0;
                        q_we       <= d_we;
                        q_size     <= d_size;
                        q_unsigned <= d_unsigned;
                        q_lane     <= d_addr[1:0];
                        if (d_bad) begin
                            state   <= RESP;
                            d_done  <= 1'b1;
                            d_err   <= 1'b1;
                            d_rdata <= 32'd0;
                        end else begin
                            state     <= BUSY_D;
                            mem_req   <= 1'b1;
                            mem_we    <= d_we;
                            mem_addr  <= {d_addr[31:2], 2'b00};
                            mem_be    <= d_be;
                            mem_wdata <= d_wdata_rep;
                            wait_cnt  <= 8'd0;
                        end
                    end else if (grant_if) begin
                        streak    <= 4'd0;
                        state     <= BUSY_IF;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= {if_addr[31:2], 2'b00};
                        mem_be    <= 4'b1111;
                        mem_wdata <= 32'd0;
                        wait_cnt  <= 8'd0;
                    end
                end
                BUSY_IF: begin
                    if (mem_ack) begin
                        mem_req  <= 1'b0;
                        if_done  <= 1'b1;
                        if_rdata <= mem_rdata;
                        state    <= RESP;
                    end else if (wait_cnt == WAIT_LIM) begin
                        mem_req  <= 1'b0;
                        if_done  <= 1'b1;
                        if_err   <= 1'b1;
                        if_rdata <= 32'd0;
                        state    <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                BUSY_D: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        d_done  <= 1'b1;
                        d_rdata <= q_we ? 32'd0 : load_data;
                        state   <= RESP;
                    end else if (wait_cnt == WAIT_LIM) begin
                        mem_req <= 1'b0;
                        d_done  <= 1'b1;
                        d_err   <= 1'b1;
                        d_rdata <= 32'd0;
                        state   <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, corner-case
// sequences and randomized transactions against a spec-level reference model.
module tb_mem_port_arbiter;
    localparam int STREAK_MAX = 4;
    localparam int TIMEOUT    = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'd0;
    logic        if_done;
    logic [31:0] if_rdata;
    logic        if_err;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [1:0]  d_size = 2'b00;
    logic        d_unsigned = 1'b0;
    logic [31:0] d_addr = 32'd0;
    logic [31:0] d_wdata = 32'd0;
    logic        d_done;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'd0;

    mem_port_arbiter #(.STREAK_MAX(STREAK_MAX), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_unsigned(d_unsigned), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_done(d_done), .d_rdata(d_rdata), .d_err(d_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // scoreboard
    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endfunction

    // reference model, written from the access-size arithmetic
    function automatic bit m_bad(input logic [1:0] size, input logic [31:0] addr);
        return (size == 2'd3) || (size == 2'd1 && (addr % 2) != 0) || (size == 2'd2 && (addr % 4) != 0);
    endfunction

    function automatic int m_bytes(input logic [1:0] size);
        return 1 << size;
    endfunction

    function automatic logic [3:0] m_be(input logic [1:0] size, input logic [31:0] addr);
        int v;
        v = ((1 << m_bytes(size)) - 1) << (addr % 4);
        return v[3:0];
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] size, input logic [31:0] wd);
        case (m_bytes(size))
            1:       return {24'd0, wd[7:0]} * 32'h0101_0101;
            2:       return {16'd0, wd[15:0]} * 32'h0001_0001;
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] m_rdata(input logic [1:0] size, input bit uns,
                                            input logic [31:0] addr, input logic [31:0] rd);
        int nb;
        logic [31:0] v, mask;
        nb = m_bytes(size);
        if (nb == 4) return rd;
        v    = rd >> (8 * (addr % 4));
        mask = (32'd1 << (8 * nb)) - 32'd1;
        v    = v & mask;
        if (!uns && v[8 * nb - 1]) v = v | ~mask;
        return v;
    endfunction

    // driver: one transaction from one requester, memory answered after `waits` cycles
    // (waits >= TIMEOUT means the memory never acknowledges). Starts and ends at a negedge
    // with the arbiter idle.
    task automatic run_txn(input bit is_d, input bit we, input logic [1:0] size, input bit uns,
                           input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rd,
                           input int waits, input logic [31:0] e_addr, input logic [3:0] e_be,
                           input logic [31:0] e_wdata, input logic [31:0] e_rdata, input bit e_bad,
                           input string tag);
        int cyc, mreq_n, lat, exp_mreq;
        bit seen, tmo, other;
        logic [31:0] exp_rd;
        tmo      = (waits >= TIMEOUT) && !e_bad;
        lat      = e_bad ? 1 : (tmo ? TIMEOUT + 1 : waits + 2);
        exp_mreq = e_bad ? 0 : (tmo ? TIMEOUT : waits + 1);
        exp_q.push_back(e_rdata);
        if (is_d) begin
            d_req = 1'b1; d_we = we; d_size = size; d_unsigned = uns; d_addr = addr; d_wdata = wdata;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        cyc = 0; mreq_n = 0; seen = 0; other = 0;
        while (!seen && cyc < TIMEOUT + 8) begin
            @(negedge clk);
            cyc++;
            mem_ack = 1'b0;
            if (mem_req) begin
                mreq_n++;
                chk({tag, " mem_be"}, 32'(mem_be), 32'(e_be));
                if (mreq_n == 1) begin
                    chk({tag, " mem_addr"}, mem_addr, e_addr);
                    chk({tag, " mem_we"}, 32'(mem_we), 32'(is_d & we));
                    if (is_d && we) chk({tag, " mem_wdata"}, mem_wdata, e_wdata);
                end
                if (mreq_n == waits + 1) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rd;
                end
            end
            if (is_d ? if_done : d_done) other = 1;
            if (is_d ? d_done : if_done) begin
                seen   = 1;
                exp_rd = exp_q.pop_front();
                chk({tag, " latency"}, 32'(cyc), 32'(lat));
                chk({tag, " mem_req_cycles"}, 32'(mreq_n), 32'(exp_mreq));
                chk({tag, " err"}, 32'(is_d ? d_err : if_err), 32'(e_bad | tmo));
                if (is_d || !tmo) chk({tag, " rdata"}, is_d ? d_rdata : if_rdata, exp_rd);
                d_req  = 1'b0;
                if_req = 1'b0;
            end
        end
        if (!seen) begin
            chk({tag, " done_seen"}, 32'd0, 32'd1);
            void'(exp_q.pop_front());
            d_req  = 1'b0;
            if_req = 1'b0;
        end
        mem_ack = 1'b0;
        chk({tag, " other_done"}, 32'(other), 32'd0);
        @(negedge clk);
    endtask

    typedef struct {
        bit          is_d;
        bit          we;
        logic [1:0]  size;
        bit          uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd;
        int          waits;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic [31:0] e_rdata;
        bit          e_bad;
    } vec_t;

    vec_t vecs[14];

    initial begin
        bit          flag;
        logic [9:0]  order;
        int          n;
        bit          r_d, r_we, r_uns;
        logic [1:0]  r_size;
        logic [31:0] r_addr, r_wd, r_rd;
        int          r_waits;
        bit          r_bad;

        //            is_d  we    size   uns   addr          wdata         rd            w  e_addr        be     e_wdata       e_rdata       bad
        vecs[0]  = '{1'b0, 1'b0, 2'd0, 1'b0, 32'h0000_0104, 32'h0,        32'h00A0_0093, 2, 32'h0000_0104, 4'hF, 32'h0,        32'h00A0_0093, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 2'd0, 1'b0, 32'h0000_0203, 32'h0,        32'h80FF_1234, 0, 32'h0000_0200, 4'h8, 32'h0,        32'hFFFF_FF80, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 2'd0, 1'b1, 32'h0000_0203, 32'h0,        32'h80FF_1234, 1, 32'h0000_0200, 4'h8, 32'h0,        32'h0000_0080, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 2'd1, 1'b0, 32'h0000_0202, 32'h0,        32'h80FF_1234, 0, 32'h0000_0200, 4'hC, 32'h0,        32'hFFFF_80FF, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 2'd1, 1'b0, 32'h0000_0102, 32'hDEAD_BEEF, 32'h0,        0, 32'h0000_0100, 4'hC, 32'hBEEF_BEEF, 32'h0,        1'b0};
        vecs[5]  = '{1'b1, 1'b1, 2'd2, 1'b0, 32'h0000_0101, 32'h1234_5678, 32'h0,        0, 32'h0,        4'h0, 32'h0,        32'h0,        1'b1};
        vecs[6]  = '{1'b1, 1'b0, 2'd3, 1'b0, 32'h0000_0100, 32'h0,        32'h0,        0, 32'h0,        4'h0, 32'h0,        32'h0,        1'b1};
        vecs[7]  = '{1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0200, 32'h0,        32'h80FF_1234, 3, 32'h0000_0200, 4'hF, 32'h0,        32'h80FF_1234, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 2'd1, 1'b1, 32'h0000_0200, 32'h0,        32'h80FF_1234, 0, 32'h0000_0200, 4'h3, 32'h0,        32'h0000_1234, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 2'd0, 1'b0, 32'h0000_0101, 32'h0000_00AB, 32'h0,        0, 32'h0000_0100, 4'h2, 32'hABAB_ABAB, 32'h0,        1'b0};
        vecs[10] = '{1'b1, 1'b0, 2'd1, 1'b0, 32'h0000_0201, 32'h0,        32'h0,        0, 32'h0,        4'h0, 32'h0,        32'h0,        1'b1};
        vecs[11] = '{1'b0, 1'b0, 2'd0, 1'b0, 32'h0000_0007, 32'h0,        32'h0000_0013, 0, 32'h0000_0004, 4'hF, 32'h0,        32'h0000_0013, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 2'd0, 1'b0, 32'h0000_0201, 32'h0,        32'h80FF_1234, 0, 32'h0000_0200, 4'h2, 32'h0,        32'h0000_0012, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 2'd1, 1'b0, 32'h0000_0200, 32'h0,        32'h1234_F00D, 1, 32'h0000_0200, 4'h3, 32'h0,        32'hFFFF_F00D, 1'b0};

        // reset state
        repeat (3) @(negedge clk);
        chk("reset mem_req", 32'(mem_req), 32'd0);
        chk("reset mem_be", 32'(mem_be), 32'd0);
        chk("reset mem_addr", mem_addr, 32'd0);
        chk("reset if_done", 32'(if_done), 32'd0);
        chk("reset d_done", 32'(d_done), 32'd0);
        chk("reset d_rdata", d_rdata, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // directed vector table
        for (int i = 0; i < 14; i++) begin
            run_txn(vecs[i].is_d, vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
                    vecs[i].rd, vecs[i].waits, vecs[i].e_addr, vecs[i].e_be, vecs[i].e_wdata,
                    vecs[i].e_rdata, vecs[i].e_bad, $sformatf("vec%0d", i));
        end

        // data timeout, then a late ack that must be ignored
        run_txn(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0300, 32'h0, 32'h5555_AAAA, TIMEOUT,
                32'h0000_0300, 4'hF, 32'h0, 32'h0, 1'b0, "d_timeout");
        repeat (2) @(negedge clk);
        mem_ack   = 1'b1;
        mem_rdata = 32'h1111_2222;
        flag = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (d_done || if_done || mem_req || d_err) flag = 1;
        end
        chk("late_ack ignored", 32'(flag), 32'd0);
        run_txn(1'b0, 1'b0, 2'd0, 1'b0, 32'h0000_0400, 32'h0, 32'hCAFE_0001, TIMEOUT,
                32'h0000_0400, 4'hF, 32'h0, 32'h0, 1'b0, "if_timeout");
        run_txn(1'b0, 1'b0, 2'd0, 1'b0, 32'h0000_0408, 32'h0, 32'hCAFE_0002, 0,
                32'h0000_0408, 4'hF, 32'h0, 32'hCAFE_0002, 1'b0, "after_timeout");

        // both requesters held: data streak then forced fetch
        if_req = 1'b1; if_addr = 32'h0000_0080;
        d_req = 1'b1; d_we = 1'b0; d_size = 2'd2; d_unsigned = 1'b0; d_addr = 32'h0000_0040;
        order = 10'd0; n = 0; flag = 0;
        for (int c = 0; c < 200 && n < 10; c++) begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (mem_req) begin
                mem_ack   = 1'b1;
                mem_rdata = 32'h0BAD_F00D;
            end
            if (d_done && if_done) flag = 1;
            if (d_done || if_done) begin
                order[9 - n] = if_done;
                n++;
            end
        end
        if_req = 1'b0; d_req = 1'b0; mem_ack = 1'b0;
        chk("arb grant_count", 32'(n), 32'd10);
        chk("arb order", 32'(order), 32'b00_0010_0001);
        chk("arb dual_done", 32'(flag), 32'd0);
        repeat (2) @(negedge clk);

        // reset while a data access is in flight
        d_req = 1'b1; d_we = 1'b0; d_size = 2'd2; d_addr = 32'h0000_0500;
        @(negedge clk);
        chk("rst_mid mem_req_before", 32'(mem_req), 32'd1);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("rst_mid mem_req_async", 32'(mem_req), 32'd0);
        chk("rst_mid d_done", 32'(d_done), 32'd0);
        @(negedge clk);
        d_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        flag = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (d_done || if_done || mem_req) flag = 1;
        end
        chk("rst_mid no_done", 32'(flag), 32'd0);

        // randomized transactions against the reference model
        for (int i = 0; i < 40; i++) begin
            r_d     = 1'($urandom_range(0, 1));
            r_we    = 1'($urandom_range(0, 1));
            r_uns   = 1'($urandom_range(0, 1));
            r_size  = 2'($urandom_range(0, 3));
            r_addr  = $urandom & 32'h000F_FFFF;
            r_wd    = $urandom;
            r_rd    = $urandom;
            r_waits = $urandom_range(0, 3);
            if (r_d) begin
                r_bad = m_bad(r_size, r_addr);
                run_txn(1'b1, r_we, r_size, r_uns, r_addr, r_wd, r_rd, r_waits,
                        r_addr & ~32'd3, m_be(r_size, r_addr), m_wdata(r_size, r_wd),
                        (r_bad || r_we) ? 32'd0 : m_rdata(r_size, r_uns, r_addr, r_rd),
                        r_bad, $sformatf("rnd%0d_d", i));
            end else begin
                run_txn(1'b0, 1'b0, 2'd0, 1'b0, r_addr, 32'd0, r_rd, r_waits,
                        r_addr & ~32'd3, 4'hF, 32'd0, r_rd, 1'b0, $sformatf("rnd%0d_if", i));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequential arbiter and sequencer that shares the single-ported unified memory between the instruction-fetch path and the load/store path of the RISC-V core. Grants one requester at a time and drives the memory handshake. Performs byte-lane alignment, byte enables and load sign/zero extension for byte, half and word accesses. Flags misaligned accesses and memory timeouts back to the requester.

## Interface
- STREAK_MAX, 4: maximum consecutive data grants while a fetch is pending before fetch is forced (1..15)
- TIMEOUT, 16: cycles mem_req may stay high without mem_ack before abort (2..255)

- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request, level, held until if_done
- if_addr  in  32  fetch byte address (bits [1:0] ignored)
- if_done  out  1  one-cycle response pulse
- if_rdata  out  32  fetched word, valid with if_done
- if_err  out  1  timeout flag, valid with if_done
- d_req  in  1  data request, level, held until d_done
- d_we  in  1  1 = store, 0 = load
- d_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- d_unsigned  in  1  zero-extend loads (LBU/LHU)
- d_addr  in  32  data byte address
- d_wdata  in  32  store data, right-justified
- d_done  out  1  one-cycle response pulse
- d_rdata  out  32  extended load data, valid with d_done; 0 for stores/errors
- d_err  out  1  misaligned/illegal size or timeout, valid with d_done
- mem_req  out  1  memory request, registered
- mem_we  out  1  memory write enable
- mem_addr  out  32  word address, bits [1:0] forced 0
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-replicated store data
- mem_ack  in  1  memory completion, single cycle
- mem_rdata  in  32  read word, valid with mem_ack

## Operation
- States: IDLE, BUSY_IF, BUSY_D, RESP. All outputs registered.
- IDLE: samples requests.
  - d_req only -> data.
  - if_req only -> fetch.
  - Both high -> data, unless streak == STREAK_MAX, in which case fetch.
- Streak counter:
  - Incremented on each data grant made while if_req is high.
  - Cleared on a fetch grant.
  - Cleared on a data grant with if_req low.
- Data alignment check at grant:
  - Illegal: d_size 11; half with addr[0]=1; word with addr[1:0]≠0.
  - Illegal grants go directly IDLE->RESP with d_err=1 and no memory cycle.
  - An illegal grant still counts as a data grant for the streak counter.
- Legal grant loads mem_* and enters BUSY_x with mem_req=1.
  - Fetch: mem_we=0, mem_be=1111.
  - Byte: mem_be = 0001<<addr[1:0], wdata = {4{d_wdata[7:0]}}.
  - Half: mem_be = addr[1] ? 1100 : 0011, wdata = {2{d_wdata[15:0]}}.
  - Word: mem_be = 1111, wdata = d_wdata.
  - Loads drive the same mem_be with mem_we=0.
- BUSY_x: holds mem_* stable.
  - mem_ack=1 -> mem_req=0, capture response, go to RESP.
  - TIMEOUT cycles of mem_req without ack -> mem_req=0, err=1, go to RESP.
- Load extraction:
  - Byte: mem_rdata[8·addr[1:0] +: 8].
  - Half: mem_rdata[16·addr[1] +: 16].
  - Sign-extend unless d_unsigned.
- RESP: the owning done pulses one cycle, requests are ignored, then IDLE.
- A requester still high in the cycle after done is a new request.
- mem_ack outside BUSY_x (including a late ack after timeout) is ignored.

## Timing
- Reset (rst low, async): state IDLE, counters 0, all outputs 0; an in-flight mem_req drops immediately and no done is issued.
- Minimum transaction: request seen cycle 0, mem_req=1 cycle 1, ack cycle 1, done cycle 2, IDLE cycle 3. Three-cycle throughput.
- Memory stall: each wait cycle adds one cycle of latency.
- Misaligned access: request cycle 0, d_done+d_err cycle 1.
- Timeout: mem_req high for exactly TIMEOUT cycles, done+err on the following cycle.
- done, err and rdata are valid only in the done cycle; the rest of the time rdata holds its last value and err=0.

## Test plan
- Single fetch, addr 0x0000_0104, ack after 2 wait cycles, mem_rdata 0x00A00093 -> mem_addr 0x104, be 1111; if_done 4 cycles after request, if_rdata 0x00A00093, if_err 0.
- LB addr 0x203, mem_rdata 0x80FF_1234 -> mem_be 1000, d_rdata 0xFFFF_FF80. Repeat with LBU -> 0x0000_0080. LH addr 0x202 -> 0xFFFF_80FF.
- SH addr 0x102, d_wdata 0xDEAD_BEEF -> mem_we 1, mem_be 1100, mem_wdata 0xBEEF_BEEF, d_rdata 0.
- SW addr 0x101 -> no mem_req; d_done and d_err next cycle. d_size 11 at any address -> same response.
- if_req and d_req held continuously, STREAK_MAX=4 -> grant order D,D,D,D,IF,D,D,D,D,IF.
- mem_ack never asserted -> mem_req high exactly 16 cycles, then done+err. A late ack 3 cycles later is ignored. Assert rst mid-BUSY_D -> mem_req 0 immediately, no d_done.
